cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm.sv | 102 ++++++++++
 tb/tb_cache_fill_fsm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: on a miss, streams WORDS sequential 16-bit reads for the aligned block
// and writes each returned word into the data array, writing the tag with the last word.
`default_nettype none

module cache_fill_fsm #(
  parameter int WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        mem_read_req,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic [15:0] fill_address,
  output logic [15:0] fill_data
);

  localparam int CW = $clog2(WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS);
  localparam logic [15:0] BLK_MASK = 16'(2 * WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] icnt_q, icnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [15:0]   base_q, base_d;

  logic [15:0]   w_ioff, w_roff;

  assign w_ioff = 16'(icnt_q) << 1;
  assign w_roff = 16'(rcnt_q) << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      icnt_q  <= '0;
      rcnt_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    icnt_d           = icnt_q;
    rcnt_d           = rcnt_q;
    base_d           = base_q;
    fsm_busy         = 1'b0;
    mem_read_req     = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_address     = '0;
    fill_data        = memory_data;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d  = miss_address & ~BLK_MASK;
          icnt_d  = '0;
          rcnt_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        fsm_busy = 1'b1;
        if (icnt_q < LAST) begin
          mem_read_req   = 1'b1;
          memory_address = base_q + w_ioff;
          icnt_d         = icnt_q + 1'b1;
        end
        // Responses are counted independently of requests, so any memory latency works.
        if (memory_data_valid && (rcnt_q < LAST)) begin
          write_data_array = 1'b1;
          fill_address     = base_q + w_roff;
          rcnt_d           = rcnt_q + 1'b1;
          if (rcnt_q == LAST - 1'b1) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// Directed, table-driven bench for cache_fill_fsm (WORDS=8).
`default_nettype none

module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] fill_address;
  logic [15:0] fill_data;

  int n_pass;
  int n_total;

  cache_fill_fsm #(.WORDS(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_req      (mem_read_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_address      (fill_address),
    .fill_data         (fill_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        miss;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] data;
    logic        busy;
    logic        req;
    logic [15:0] maddr;
    logic        wr;
    logic        tag;
    logic [15:0] faddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic mi, input logic [15:0] ad, input logic vl,
                              input logic [15:0] dt, input logic bz, input logic rq,
                              input logic [15:0] ma, input logic wr, input logic tg,
                              input logic [15:0] fa);
    vec_t v;
    v.miss = mi; v.addr = ad; v.vld = vl; v.data = dt;
    v.busy = bz; v.req = rq; v.maddr = ma; v.wr = wr; v.tag = tg; v.faddr = fa;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Called at a falling edge: drive, settle, compare, advance to the next falling edge.
  task automatic step(input vec_t v, input string nm);
    miss_detected     = v.miss;
    miss_address      = v.addr;
    memory_data_valid = v.vld;
    memory_data       = v.data;
    #1;
    chk({nm, ".busy"},  16'(fsm_busy),         16'(v.busy));
    chk({nm, ".req"},   16'(mem_read_req),     16'(v.req));
    chk({nm, ".maddr"}, memory_address,        v.maddr);
    chk({nm, ".wr"},    16'(write_data_array), 16'(v.wr));
    chk({nm, ".tag"},   16'(write_tag_array),  16'(v.tag));
    chk({nm, ".faddr"}, fill_address,          v.faddr);
    chk({nm, ".fdata"}, fill_data,             v.data);
    @(negedge clk);
  endtask

  task automatic run_fill(input string nm, input logic [15:0] miss_a, input logic [15:0] base,
                          input int lat, input int pulse_k);
    step(mk(1'b1, miss_a, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0), {nm, ".idle"});
    for (int k = 0; k < 8 + lat; k++) begin
      step(mk(k == pulse_k, 16'h4000, k >= lat, 16'hD000 + 16'(k),
              1'b1, k < 8, (k < 8) ? base + 16'(2 * k) : 16'h0,
              k >= lat, k == 7 + lat, (k >= lat) ? base + 16'(2 * (k - lat)) : 16'h0),
           $sformatf("%s.c%0d", nm, k));
    end
    step(mk(1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0), {nm, ".done"});
    step(mk(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0), {nm, ".quiet"});
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    // Fill at 0x1236 with memory latency 4, preceded by a spurious response in IDLE.
    tbl.push_back(mk(0, 16'h0000, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 16'h1236, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 1, 16'h1230, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 16'h5555, 0, 16'h0000, 1, 1, 16'h1232, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 1, 16'h1234, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 1, 16'h1236, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA000, 1, 1, 16'h1238, 1, 0, 16'h1230));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA001, 1, 1, 16'h123A, 1, 0, 16'h1232));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA002, 1, 1, 16'h123C, 1, 0, 16'h1234));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA003, 1, 1, 16'h123E, 1, 0, 16'h1236));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA004, 1, 0, 16'h0000, 1, 0, 16'h1238));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA005, 1, 0, 16'h0000, 1, 0, 16'h123A));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA006, 1, 0, 16'h0000, 1, 0, 16'h123C));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA007, 1, 0, 16'h0000, 1, 1, 16'h123E));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000));

    rst_n             = 1'b0;
    miss_detected     = 1'b1;
    miss_address      = 16'h1236;
    memory_data_valid = 1'b1;
    memory_data       = 16'h1111;
    @(negedge clk);
    chk("rst.busy",  16'(fsm_busy),         16'h0);
    chk("rst.req",   16'(mem_read_req),     16'h0);
    chk("rst.maddr", memory_address,        16'h0);
    chk("rst.wr",    16'(write_data_array), 16'h0);
    chk("rst.tag",   16'(write_tag_array),  16'h0);
    chk("rst.faddr", fill_address,          16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("tbl%0d", i));

    run_fill("lat0", 16'h0000, 16'h0000, 0, -1);
    run_fill("remiss", 16'h2000, 16'h2000, 2, 3);
    run_fill("top", 16'hFFFE, 16'hFFF0, 0, -1);

    // Abort a fill at 0x8000 after its third write.
    step(mk(1, 16'h8000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000), "abt.idle");
    for (int k = 0; k < 3; k++)
      step(mk(0, 16'h0000, 1, 16'hC000 + 16'(k), 1, 1, 16'h8000 + 16'(2 * k),
              1, 0, 16'h8000 + 16'(2 * k)), $sformatf("abt.c%0d", k));
    miss_detected     = 1'b0;
    memory_data_valid = 1'b1;
    memory_data       = 16'hC003;
    #1;
    rst_n = 1'b0;
    #1;
    chk("abt.busy",  16'(fsm_busy),         16'h0);
    chk("abt.req",   16'(mem_read_req),     16'h0);
    chk("abt.maddr", memory_address,        16'h0);
    chk("abt.wr",    16'(write_data_array), 16'h0);
    chk("abt.tag",   16'(write_tag_array),  16'h0);
    chk("abt.faddr", fill_address,          16'h0);
    @(negedge clk);
    #1;
    chk("abt.hold.wr",  16'(write_data_array), 16'h0);
    chk("abt.hold.tag", 16'(write_tag_array),  16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_fill("post", 16'h9008, 16'h9000, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
